// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, multi-cycle FSM state
// encodings and the default datapath width.
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_SRL   = 4'h4,
    OP_SRA   = 4'h5,
    OP_SLL   = 4'h6,
    OP_SLT   = 4'h7,
    OP_SLTU  = 4'h8,
    OP_XOR   = 4'h9,
    OP_MULT  = 4'hA,
    OP_MULTU = 4'hB,
    OP_DIV   = 4'hC,
    OP_DIVU  = 4'hD,
    OP_MFHI  = 4'hE,
    OP_MFLO  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Ops that go through the iterative multiply/divide unit.
  function automatic logic is_multi(op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/result bundle of the iterative ALU.
//   start, op, a, b : request (driven by master)
//   c, hi, lo       : registered result / architectural HI/LO (driven by slave)
//   busy, done      : multi-cycle in progress / one-cycle result-valid pulse
interface alu_iter_if import alu_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input c, hi, lo, busy, done);
  modport slave  (input start, op, a, b, output c, hi, lo, busy, done);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, op, a, b : load request (op is one of mult/multu/div/divu)
//   busy            : iterating (RUN state)
//   last            : final iteration cycle; res_hi/res_lo are valid now
//   done            : one-cycle pulse after the final iteration (FIN state)
//   res_hi, res_lo  : final result {hi,lo}, combinational, valid with last
// Signed ops run on magnitudes; signs are reapplied on the last cycle.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CW = $clog2(WIDTH);

  state_e           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rh, rl, opb, a_org;
  logic             is_div, neg_q, neg_r, div0;

  // Operand preparation at load.
  logic             ld, sgn, sa, sb, ld_div;
  logic [WIDTH-1:0] ua, ub;

  assign ld     = start && (state != ST_RUN);
  assign ld_div = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign sa     = sgn & a[WIDTH-1];
  assign sb     = sgn & b[WIDTH-1];
  assign ua     = sa ? -a : a;
  assign ub     = sb ? -b : b;

  assign busy = (state == ST_RUN);
  assign last = busy && (cnt == CW'(WIDTH-1));
  assign done = (state == ST_FIN);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_RUN;
      ST_RUN:  if (last)  nxt = ST_FIN;
      ST_FIN:  nxt = start ? ST_RUN : ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // One iteration step.
  logic [WIDTH:0]   sum, shifted;
  logic             qbit;
  logic [WIDTH-1:0] step_h, step_l;

  always_comb begin
    // multiply: {rh,rl} >>= 1 after conditionally adding the multiplicand
    sum     = {1'b0, rh} + (rl[0] ? {1'b0, opb} : '0);
    // divide: {rh,rl} <<= 1, subtract the divisor if it fits
    shifted = {rh, rl[WIDTH-1]};
    qbit    = (shifted >= {1'b0, opb});
    step_h  = '0;
    step_l  = '0;
    if (is_div) begin
      step_h = qbit ? WIDTH'(shifted - {1'b0, opb}) : shifted[WIDTH-1:0];
      step_l = {rl[WIDTH-2:0], qbit};
    end else begin
      step_h = sum[WIDTH:1];
      step_l = {sum[0], rl[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      rh     <= '0;
      rl     <= '0;
      opb    <= '0;
      a_org  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (ld) begin
      cnt    <= '0;
      rh     <= '0;
      rl     <= ld_div ? ua : ub;
      opb    <= ld_div ? ub : ua;
      a_org  <= a;
      is_div <= ld_div;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      div0   <= (b == '0);
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      rh  <= step_h;
      rl  <= step_l;
    end
  end

  // Sign fix-up of the final step. Most-negative / -1 falls out naturally:
  // magnitude quotient 2^(W-1) negates back to itself, remainder 0.
  logic [2*WIDTH-1:0] prod, prod_n;

  always_comb begin
    prod   = {step_h, step_l};
    prod_n = neg_q ? -prod : prod;
    res_hi = prod_n[2*WIDTH-1:WIDTH];
    res_lo = prod_n[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        res_lo = '1;
        res_hi = a_org;
      end else begin
        res_lo = neg_q ? -step_l : step_l;
        res_hi = neg_r ? -step_h : step_h;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU top: single-cycle logic/arith/shift/compare/mfhi/mflo ops,
// plus multi-cycle mult/multu/div/divu through alu_muldiv_iter.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   io    : alu_iter_if slave (start/op/a/b in; c/hi/lo/busy/done out)
module alu_iter import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       reset,
  alu_iter_if.slave io
);
  logic             accept, multi, md_start, md_busy, md_last, md_done;
  logic             done_q;
  logic [WIDTH-1:0] md_hi, md_lo, res, c_q, hi_q, lo_q;
  logic [SHW-1:0]   shamt;

  assign multi    = is_multi(io.op);
  assign accept   = io.start & ~md_busy;
  assign md_start = accept & multi;
  assign shamt    = io.b[SHW-1:0];

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (io.op),
    .a      (io.a),
    .b      (io.b),
    .busy   (md_busy),
    .last   (md_last),
    .done   (md_done),
    .res_hi (md_hi),
    .res_lo (md_lo)
  );

  always_comb begin
    res = '0;
    case (io.op)
      OP_ADD:  res = io.a + io.b;
      OP_SUB:  res = io.a - io.b;
      OP_AND:  res = io.a & io.b;
      OP_OR:   res = io.a | io.b;
      OP_SRL:  res = io.a >> shamt;
      OP_SRA:  res = $signed(io.a) >>> shamt;
      OP_SLL:  res = io.a << shamt;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(io.a) < $signed(io.b)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, io.a < io.b};
      OP_XOR:  res = io.a ^ io.b;
      OP_MFHI: res = hi_q;
      OP_MFLO: res = lo_q;
      default: res = '0;
    endcase
  end

  // accept and md_last are exclusive: md_last only occurs while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= accept & ~multi;
      if (accept && !multi) c_q <= res;
      if (md_last) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
        c_q  <= md_lo;
      end
    end
  end

  assign io.c    = c_q;
  assign io.hi   = hi_q;
  assign io.lo   = lo_q;
  assign io.busy = md_busy;
  assign io.done = done_q | md_done;

endmodule
